// File: rtl/result_packer_pkg.sv
// result_packer_pkg: harness constants and packing-state type shared with the upstream BFM
package result_packer_pkg;
  localparam int TOTAL_WIDTH = 256;
  localparam int BYTE_W = 8;
  localparam int LEN_W = 6;
  typedef enum logic {IDLE, FILL} pack_state_e;
endpackage

// File: rtl/result_packer.sv
// result_packer: packs result bytes LSB-first into wide vectors with a single holding register and drop accounting
module result_packer #(
  parameter int TOTAL_WIDTH = result_packer_pkg::TOTAL_WIDTH,
  parameter int BYTE_W = result_packer_pkg::BYTE_W
) (
  input  logic                                 clk_i,
  input  logic                                 reset_ni,
  input  logic [BYTE_W-1:0]                    res_i,
  input  logic                                 res_valid_i,
  input  logic                                 flush_i,
  output logic [TOTAL_WIDTH-1:0]               vec_o,
  output logic [result_packer_pkg::LEN_W-1:0]  vec_len_o,
  output logic                                 vec_valid_o,
  input  logic                                 vec_ready_i,
  output logic                                 overflow_o,
  output logic [15:0]                          drop_cnt_o,
  input  logic                                 clr_ovf_i
);
  import result_packer_pkg::*;
  localparam int NB = TOTAL_WIDTH / BYTE_W;
  localparam int CW = $clog2(NB);
  pack_state_e state, state_nx;
  logic [CW-1:0] cnt;
  logic [TOTAL_WIDTH-1:0] pack, pack_nx;
  logic [LEN_W-1:0] len;
  logic done, load, drop;
  always_comb begin
    pack_nx = pack;
    if (res_valid_i) pack_nx[cnt*BYTE_W +: BYTE_W] = res_i;
    done = (res_valid_i && cnt == CW'(NB-1)) || (flush_i && (cnt != '0 || res_valid_i));
    len = LEN_W'(cnt) + LEN_W'(res_valid_i);
    load = done && (!vec_valid_o || vec_ready_i);
    drop = done && vec_valid_o && !vec_ready_i;
    state_nx = state == IDLE ? ((res_valid_i && !done) ? FILL : IDLE) : (done ? IDLE : FILL);
  end
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      cnt <= '0;
      pack <= '0;
    end else if (done) begin
      cnt <= '0;
      pack <= '0;
    end else if (res_valid_i) begin
      cnt <= cnt + 1'b1;
      pack <= pack_nx;
    end
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      vec_o <= '0;
      vec_len_o <= '0;
      vec_valid_o <= 1'b0;
    end else if (load) begin
      vec_o <= pack_nx;
      vec_len_o <= len;
      vec_valid_o <= 1'b1;
    end else if (vec_ready_i) vec_valid_o <= 1'b0;
  // a drop in the same cycle as a clear restarts the count at one
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      drop_cnt_o <= clr_ovf_i ? 16'd1 : ((&drop_cnt_o) ? drop_cnt_o : drop_cnt_o + 16'd1);
    end else if (clr_ovf_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end
endmodule

// File: tb/tb_result_packer.sv
// tb_result_packer: directed and random checks of result_packer against a byte-queue reference model
module tb_result_packer;
  logic clk_i = 1'b0;
  logic reset_ni = 1'b0;
  logic [7:0] res_i = '0;
  logic res_valid_i = 1'b0;
  logic flush_i = 1'b0;
  logic [255:0] vec_o;
  logic [5:0] vec_len_o;
  logic vec_valid_o;
  logic vec_ready_i = 1'b1;
  logic overflow_o;
  logic [15:0] drop_cnt_o;
  logic clr_ovf_i = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [7:0] m_cur[$];
  logic [255:0] m_vec;
  logic [5:0] m_len;
  logic m_valid, m_ovf;
  logic [15:0] m_drops;
  logic [7:0] b[64];
  logic [255:0] want_vec;

  result_packer dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .res_i(res_i), .res_valid_i(res_valid_i),
    .flush_i(flush_i), .vec_o(vec_o), .vec_len_o(vec_len_o), .vec_valid_o(vec_valid_o),
    .vec_ready_i(vec_ready_i), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o), .clr_ovf_i(clr_ovf_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_cur.delete();
    m_vec = '0;
    m_len = '0;
    m_valid = 1'b0;
    m_ovf = 1'b0;
    m_drops = '0;
  endtask

  // one clock of the packer described as a byte queue and a single output slot
  task automatic model_step();
    logic [255:0] v;
    logic dropped;
    v = '0;
    dropped = 1'b0;
    if (res_valid_i) m_cur.push_back(res_i);
    if (m_cur.size() == 32 || (flush_i && m_cur.size() > 0)) begin
      foreach (m_cur[i]) v[i*8 +: 8] = m_cur[i];
      if (!m_valid || vec_ready_i) begin
        m_vec = v;
        m_len = 6'(m_cur.size());
        m_valid = 1'b1;
      end else begin
        dropped = 1'b1;
        m_ovf = 1'b1;
        m_drops = clr_ovf_i ? 16'd1 : (m_drops == 16'hFFFF ? m_drops : m_drops + 16'd1);
      end
      m_cur.delete();
    end else if (m_valid && vec_ready_i) m_valid = 1'b0;
    if (!dropped && clr_ovf_i) begin
      m_ovf = 1'b0;
      m_drops = '0;
    end
  endtask

  task automatic check_all();
    chk("vec_valid", vec_valid_o, m_valid);
    if (m_valid) begin
      chk("vec", vec_o, m_vec);
      chk("vec_len", vec_len_o, m_len);
    end
    chk("overflow", overflow_o, m_ovf);
    chk("drop_cnt", drop_cnt_o, m_drops);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] d, input logic fl);
    res_i = d;
    res_valid_i = 1'b1;
    flush_i = fl;
    tick();
    res_valid_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_ni = 1'b0;
    #2;
    model_reset();
    chk("rst_vec", vec_o, '0);
    chk("rst_len", vec_len_o, '0);
    chk("rst_valid", vec_valid_o, 1'b0);
    chk("rst_ovf", overflow_o, 1'b0);
    chk("rst_drops", drop_cnt_o, '0);
    reset_ni = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();
    // 32 consecutive bytes, always ready
    for (int i = 0; i < 32; i++) send(8'(i), 1'b0);
    chk("full_valid", vec_valid_o, 1'b1);
    chk("full_len", vec_len_o, 6'd32);
    chk("full_lo", vec_o[7:0], 8'h00);
    chk("full_hi", vec_o[255:248], 8'h1F);
    tick();
    // five bytes then a standalone flush
    for (int i = 0; i < 5; i++) send(8'hA1 + 8'(i), 1'b0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush5_len", vec_len_o, 6'd5);
    chk("flush5_vec", vec_o, 256'hA5A4A3A2A1);
    tick();
    // flush coincident with the third byte
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    chk("flush3_len", vec_len_o, 6'd3);
    chk("flush3_vec", vec_o, 256'h332211);
    tick();
    // stalled consumer across two full vectors
    vec_ready_i = 1'b0;
    want_vec = '0;
    for (int i = 0; i < 64; i++) begin
      b[i] = 8'($urandom);
      send(b[i], 1'b0);
      if (i < 32) want_vec[i*8 +: 8] = b[i];
      if (i == 31) chk("stall_first", vec_o, want_vec);
    end
    chk("stall_held", vec_o, want_vec);
    chk("stall_ovf", overflow_o, 1'b1);
    chk("stall_drops", drop_cnt_o, 16'd1);
    clr_ovf_i = 1'b1;
    tick();
    clr_ovf_i = 1'b0;
    chk("clr_ovf", overflow_o, 1'b0);
    chk("clr_drops", drop_cnt_o, 16'd0);
    vec_ready_i = 1'b1;
    tick();
    // flush with nothing packed
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("empty_flush", vec_valid_o, 1'b0);
    // reset in the middle of a vector
    for (int i = 0; i < 10; i++) send(8'hE0 + 8'(i), 1'b0);
    do_reset();
    want_vec = '0;
    for (int i = 0; i < 32; i++) begin
      send(8'h40 + 8'(i), 1'b0);
      want_vec[i*8 +: 8] = 8'h40 + 8'(i);
    end
    chk("rst_lo", vec_o[7:0], 8'h40);
    chk("rst_len32", vec_len_o, 6'd32);
    chk("rst_clean", vec_o, want_vec);
    tick();
    // random traffic with backpressure, flushes and clears
    for (int i = 0; i < 1500; i++) begin
      res_i = 8'($urandom);
      res_valid_i = $urandom_range(0, 9) < 7;
      flush_i = $urandom_range(0, 9) == 0;
      vec_ready_i = 1'($urandom_range(0, 1));
      clr_ovf_i = $urandom_range(0, 29) == 0;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
